// File: rtl/lfsr_frame_feeder.sv
// ---------------------------------------------------------------------------
// lfsr_frame_feeder
//
// Purpose: buffers framed bytes in a small FIFO and serializes them, one bit
// per clock, into a downstream serial LFSR. Each frame is followed by
// FLUSH_LEN appended zero bits. A frame that runs dry before its last byte
// is aborted (underrun) and its remaining bytes are discarded.
//
// Parameters:
//   DEPTH      FIFO depth in bytes (power of 2, >= 2)
//   FLUSH_LEN  zero bits appended after each frame (>= 1)
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   s_data      frame byte
//   s_valid     s_data / s_last valid
//   s_last      byte is the last of its frame
//   s_ready     FIFO can accept a byte (low while rst is high)
//   lfsr_init   high holds the downstream LFSR at its seed
//   lfsr_sin    serial bit to the LFSR
//   bit_valid   lfsr_sin carries a payload bit
//   flush       lfsr_sin carries an appended zero bit
//   frame_done  one-cycle pulse on the last flush bit
//   underrun    one-cycle pulse when a frame is aborted
//
// Build option:
//   LFSR_FEEDER_LSB_FIRST_EN  when defined, bytes serialize LSB first;
//                             otherwise MSB first. Timing is identical.
// ---------------------------------------------------------------------------
module lfsr_frame_feeder #(
  parameter int DEPTH     = 4,
  parameter int FLUSH_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       lfsr_init,
  output logic       lfsr_sin,
  output logic       bit_valid,
  output logic       flush,
  output logic       frame_done,
  output logic       underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  localparam logic [AW:0]   PTR_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   FULL_FILL = (AW+1)'(DEPTH);
  localparam logic [FW-1:0] FCNT_ZERO = {FW{1'b0}};
  localparam logic [FW-1:0] FCNT_ONE  = FW'(1);
  localparam logic [FW-1:0] FCNT_END  = FW'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  // Bit presented to the LFSR from the current shifter contents.
  function automatic logic serial_bit(input logic [7:0] b);
`ifdef LFSR_FEEDER_LSB_FIRST_EN
    serial_bit = b[0];
`else
    serial_bit = b[7];
`endif
  endfunction

  // Shifter contents after one bit has been sent.
  function automatic logic [7:0] shift_byte(input logic [7:0] b);
`ifdef LFSR_FEEDER_LSB_FIRST_EN
    shift_byte = {1'b0, b[7:1]};
`else
    shift_byte = {b[6:0], 1'b0};
`endif
  endfunction

  // FIFO storage: {last, data}; pointers carry one extra wrap bit.
  logic [8:0]    mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [AW:0]   fill_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          ready_s;
  logic [8:0]    head_s;

  // Serializer state.
  state_t        state_r;
  state_t        state_nx;
  logic [7:0]    shift_r;
  logic [7:0]    shift_nx;
  logic          last_r;
  logic          last_nx;
  logic [2:0]    bit_cnt_r;
  logic [2:0]    bit_cnt_nx;
  logic [FW-1:0] flush_cnt_r;
  logic [FW-1:0] flush_cnt_nx;

  assign fill_s  = wr_ptr_r - rd_ptr_r;
  assign full_s  = (fill_s == FULL_FILL);
  assign empty_s = (fill_s == PTR_ZERO);
  assign ready_s = ~full_s & ~rst;
  assign push_s  = s_valid & ready_s;
  assign head_s  = mem_r[rd_ptr_r[AW-1:0]];
  assign s_ready = ready_s;

  // FIFO data write on an accepted byte.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {s_last, s_data};
    end
  end

  // FIFO pointers; a simultaneous push and pop moves both, leaving the fill unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Serializer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      shift_r     <= 8'h00;
      last_r      <= 1'b0;
      bit_cnt_r   <= 3'd0;
      flush_cnt_r <= FCNT_ZERO;
    end else begin
      state_r     <= state_nx;
      shift_r     <= shift_nx;
      last_r      <= last_nx;
      bit_cnt_r   <= bit_cnt_nx;
      flush_cnt_r <= flush_cnt_nx;
    end
  end

  // Next-state logic and FIFO pop decision (depends on registered state only).
  always_comb begin
    state_nx     = state_r;
    shift_nx     = shift_r;
    last_nx      = last_r;
    bit_cnt_nx   = bit_cnt_r;
    flush_cnt_nx = flush_cnt_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s      = 1'b1;
          shift_nx   = head_s[7:0];
          last_nx    = head_s[8];
          bit_cnt_nx = 3'd0;
          state_nx   = ST_DATA;
        end else begin
          state_nx   = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bit_cnt_r == 3'd7) begin
          if (last_r) begin
            flush_cnt_nx = FCNT_ZERO;
            state_nx     = ST_FLUSH;
          end else if (!empty_s) begin
            // Back-to-back byte: reload without a gap cycle.
            pop_s        = 1'b1;
            shift_nx     = head_s[7:0];
            last_nx      = head_s[8];
            bit_cnt_nx   = 3'd0;
            state_nx     = ST_DATA;
          end else begin
            state_nx     = ST_DROP;
          end
        end else begin
          shift_nx   = shift_byte(shift_r);
          bit_cnt_nx = bit_cnt_r + 3'd1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r == FCNT_END) begin
          state_nx     = ST_IDLE;
        end else begin
          flush_cnt_nx = flush_cnt_r + FCNT_ONE;
        end
      end
      ST_DROP: begin
        // Discard the rest of the aborted frame, up to and including its last byte.
        if (!empty_s) begin
          pop_s    = 1'b1;
          state_nx = head_s[8] ? ST_IDLE : ST_DROP;
        end else begin
          state_nx = ST_DROP;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state; reset forces the idle pattern.
  always_comb begin
    lfsr_init  = 1'b1;
    lfsr_sin   = 1'b0;
    bit_valid  = 1'b0;
    flush      = 1'b0;
    frame_done = 1'b0;
    underrun   = 1'b0;
    if (rst) begin
      lfsr_init = 1'b1;
    end else begin
      case (state_r)
        ST_DATA: begin
          lfsr_init = 1'b0;
          bit_valid = 1'b1;
          lfsr_sin  = serial_bit(shift_r);
          underrun  = (bit_cnt_r == 3'd7) & ~last_r & empty_s;
        end
        ST_FLUSH: begin
          lfsr_init  = 1'b0;
          flush      = 1'b1;
          frame_done = (flush_cnt_r == FCNT_END);
        end
        ST_IDLE: begin
          lfsr_init = 1'b1;
        end
        ST_DROP: begin
          lfsr_init = 1'b1;
        end
        default: begin
          lfsr_init = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_frame_feeder.sv
// ---------------------------------------------------------------------------
// tb_lfsr_frame_feeder
//
// Self-checking bench for lfsr_frame_feeder. A reference model keeps the
// FIFO as a queue of accepted bytes and the serial output as a queue of
// pre-expanded per-cycle symbols (8 payload bits per byte, then FLUSH_LEN
// zeros after a last byte). Every cycle the DUT outputs are compared
// against the symbol at the head of that queue. Directed scenarios are
// followed by a randomized run with occasional resets.
// ---------------------------------------------------------------------------
module tb_lfsr_frame_feeder;

  localparam int DEPTH     = 4;
  localparam int FLUSH_LEN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       lfsr_init;
  logic       lfsr_sin;
  logic       bit_valid;
  logic       flush;
  logic       frame_done;
  logic       underrun;

  always #5 clk = ~clk;

  lfsr_frame_feeder #(.DEPTH(DEPTH), .FLUSH_LEN(FLUSH_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .lfsr_init  (lfsr_init),
    .lfsr_sin   (lfsr_sin),
    .bit_valid  (bit_valid),
    .flush      (flush),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  typedef struct packed {
    logic is_flush;
    logic val;
    logic eob_nl;   // final bit of a byte that is not the frame's last
    logic fin;      // final flush bit of the frame
  } sym_t;

  sym_t       out_q[$];
  logic [8:0] fifo_q[$];
  bit         drop_m;
  bit         acc_m;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         bv_cnt;
  int         fd_cnt;
  int         ur_cnt;
  int         nr_cnt;
  logic [7:0] obs_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic order_bit(input logic [7:0] b, input int i);
`ifdef LFSR_FEEDER_LSB_FIRST_EN
    return b[i];
`else
    return b[7-i];
`endif
  endfunction

  task automatic expand(input logic [8:0] e);
    sym_t s;
    for (int i = 0; i < 8; i++) begin
      s.is_flush = 1'b0;
      s.val      = order_bit(e[7:0], i);
      s.eob_nl   = (i == 7) && !e[8];
      s.fin      = 1'b0;
      out_q.push_back(s);
    end
    if (e[8]) begin
      for (int k = 0; k < FLUSH_LEN; k++) begin
        s.is_flush = 1'b1;
        s.val      = 1'b0;
        s.eob_nl   = 1'b0;
        s.fin      = (k == FLUSH_LEN - 1);
        out_q.push_back(s);
      end
    end
  endtask

  // Advance the model across one rising edge, using the inputs the DUT sampled.
  task automatic model_step();
    logic [8:0] e;
    sym_t       s;
    bit         ready;
    acc_m = 1'b0;
    if (rst) begin
      out_q.delete();
      fifo_q.delete();
      drop_m = 1'b0;
      return;
    end
    ready = (fifo_q.size() < DEPTH);
    if (out_q.size() != 0) begin
      s = out_q.pop_front();
      if (s.eob_nl) begin
        if (fifo_q.size() != 0) begin
          e = fifo_q.pop_front();
          expand(e);
        end else begin
          drop_m = 1'b1;
        end
      end
    end else if (fifo_q.size() != 0) begin
      e = fifo_q.pop_front();
      if (drop_m) begin
        if (e[8]) drop_m = 1'b0;
      end else begin
        expand(e);
      end
    end
    if (s_valid && ready) begin
      fifo_q.push_back({s_last, s_data});
      acc_m = 1'b1;
    end
  endtask

  task automatic sample_check();
    logic [6:0] obs;
    logic [6:0] exp;
    logic       rdy;
    sym_t       s;
    rdy = !rst && (fifo_q.size() < DEPTH);
    if (rst) begin
      exp = 7'b0100000;
    end else if (out_q.size() == 0) begin
      exp = {rdy, 1'b1, 5'b00000};
    end else begin
      s = out_q[0];
      if (s.is_flush)
        exp = {rdy, 1'b0, 1'b0, 1'b0, 1'b1, s.fin, 1'b0};
      else
        exp = {rdy, 1'b0, s.val, 1'b1, 1'b0, 1'b0, s.eob_nl && (fifo_q.size() == 0)};
    end
    obs = {s_ready, lfsr_init, lfsr_sin, bit_valid, flush, frame_done, underrun};
    chk("outs", 32'(obs), 32'(exp));
    if (bit_valid === 1'b1) begin
      bv_cnt++;
      obs_byte = {obs_byte[6:0], lfsr_sin};
    end
    if (frame_done === 1'b1) fd_cnt++;
    if (underrun === 1'b1) ur_cnt++;
    if (s_ready === 1'b0 && !rst) nr_cnt++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    sample_check();
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int waited = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    cycle();
    while (!acc_m && waited < 200) begin
      cycle();
      waited++;
    end
    if (!acc_m) chk("send_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic clear_counts();
    bv_cnt   = 0;
    fd_cnt   = 0;
    ur_cnt   = 0;
    nr_cnt   = 0;
    obs_byte = 8'h00;
  endtask

  int vp;

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    drop_m  = 1'b0;
    clear_counts();
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    chk("ready_after_rst", 32'(s_ready), 32'd1);

    // Single-byte frame 0xA5 with first-bit latency.
    clear_counts();
    send(8'hA5, 1'b1);
    chk("lat_idle", 32'(bit_valid), 32'd0);
    cycle();
    chk("lat_first", 32'(bit_valid), 32'd1);
    idle(20);
    chk("a5_bits", 32'(obs_byte), 32'h000000A5);
    chk("a5_bv", 32'(bv_cnt), 32'd8);
    chk("a5_done", 32'(fd_cnt), 32'd1);
    chk("a5_init", 32'(lfsr_init), 32'd1);

    // Three bytes back to back.
    clear_counts();
    send(8'h01, 1'b0);
    send(8'h80, 1'b0);
    send(8'hFF, 1'b1);
    idle(40);
    chk("b2b_bv", 32'(bv_cnt), 32'd24);
    chk("b2b_done", 32'(fd_cnt), 32'd1);
    chk("b2b_ready", 32'(nr_cnt), 32'd0);

    // Underrun, drop of the tail, then a clean frame.
    clear_counts();
    send(8'h12, 1'b0);
    idle(20);
    send(8'h34, 1'b1);
    idle(10);
    chk("ur_pulse", 32'(ur_cnt), 32'd1);
    chk("ur_no_done", 32'(fd_cnt), 32'd0);
    chk("ur_bv", 32'(bv_cnt), 32'd8);
    clear_counts();
    send(8'h5A, 1'b1);
    idle(20);
    chk("post_ur_done", 32'(fd_cnt), 32'd1);
    chk("post_ur_bv", 32'(bv_cnt), 32'd8);
    chk("post_ur_ur", 32'(ur_cnt), 32'd0);

    // Fill the FIFO until it back-pressures; nothing may be lost.
    clear_counts();
    for (int i = 0; i < 6; i++) send(8'(($urandom & 32'hFF)), (i == 5));
    idle(80);
    chk("full_seen", 32'(nr_cnt > 0), 32'd1);
    chk("full_bv", 32'(bv_cnt), 32'd48);
    chk("full_done", 32'(fd_cnt), 32'd1);

    // Reset at bit 3 with two bytes queued.
    clear_counts();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_mid_ur", 32'(ur_cnt), 32'd0);
    clear_counts();
    rst = 1'b0;
    idle(30);
    chk("rst_mid_bv", 32'(bv_cnt), 32'd0);
    chk("rst_mid_done", 32'(fd_cnt), 32'd0);
    chk("rst_mid_ur2", 32'(ur_cnt), 32'd0);

    // Randomized traffic with bursty valid and rare resets.
    clear_counts();
    vp = 5;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 50) == 0) vp = int'($urandom_range(0, 10));
      rst     = ($urandom_range(0, 299) == 0);
      s_valid = ($urandom_range(0, 9) < vp);
      s_data  = 8'($urandom & 32'hFF);
      s_last  = ($urandom_range(0, 3) == 0);
      cycle();
    end
    rst = 1'b0;
    idle(100);
    chk("rand_frames", 32'(fd_cnt > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_frame_feeder.md
LFSR_FRAME_FEEDER -- requirements
Module: lfsr_frame_feeder

Interface
REQ-001 Parameter DEPTH, default 4, input FIFO depth in bytes; SHALL be a power of 2 and at least 2.
REQ-002 Parameter FLUSH_LEN, default 4, number of zero bits appended after each frame; SHALL be at least 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_data  input  8  frame byte.
REQ-006 s_valid  input  1  s_data/s_last valid.
REQ-007 s_last  input  1  byte is last of frame.
REQ-008 s_ready  output  1  FIFO can accept a byte.
REQ-009 lfsr_init  output  1  drives the downstream serial LFSR init; high holds it at seed.
REQ-010 lfsr_sin  output  1  serial bit to the LFSR.
REQ-011 bit_valid  output  1  lfsr_sin carries a payload bit.
REQ-012 flush  output  1  lfsr_sin carries an appended zero bit.
REQ-013 frame_done  output  1  one-cycle pulse on the last flush bit.
REQ-014 underrun  output  1  one-cycle pulse, frame aborted.

Function
REQ-015 Transfer SHALL occur on an edge where s_valid and s_ready are both high; s_ready SHALL equal FIFO not full and not rst.
REQ-016 FIFO push and pop in the same cycle SHALL both take effect; the count SHALL be unchanged.
REQ-017 All outputs except s_ready SHALL be decoded from registered state only, with no combinational path from s_* inputs.
REQ-018 States SHALL be IDLE, DATA, FLUSH and DROP.
REQ-019 IDLE: lfsr_init=1, lfsr_sin=0, bit_valid=0, flush=0; if the FIFO is non-empty, SHALL pop into an 8-bit shifter with bit count 0 and go to DATA.
REQ-020 DATA: lfsr_init=0, bit_valid=1, lfsr_sin=shifter bit 7 (MSB first); SHALL shift left one bit per cycle, with exactly 8 cycles per byte.
REQ-021 DATA, count 7, byte marked last: SHALL go to FLUSH.
REQ-022 DATA, count 7, byte not last, FIFO non-empty: SHALL pop the next byte and stay in DATA with no gap cycle.
REQ-023 DATA, count 7, byte not last, FIFO empty: SHALL pulse underrun and go to DROP.
REQ-024 FLUSH: lfsr_init=0, lfsr_sin=0, flush=1 for FLUSH_LEN cycles; frame_done=1 on the final cycle; then IDLE.
REQ-025 DROP: lfsr_init=1, bit_valid=0; SHALL pop and discard bytes until a byte with last is popped, then go to IDLE; arrival of new bytes SHALL NOT start a frame.
REQ-026 Latency: a byte accepted into an empty FIFO at edge E while in IDLE SHALL appear as its first bit with bit_valid=1 in the cycle after edge E+1.
REQ-027 A frame of N bytes SHALL produce exactly 8N+FLUSH_LEN consecutive cycles with lfsr_init=0.
REQ-028 A single-byte frame with last=1 SHALL be legal.

Reset
REQ-029 While rst is high at an edge: state SHALL become IDLE and the FIFO SHALL be empty.
REQ-030 While rst is high: lfsr_init=1; lfsr_sin, bit_valid, flush, frame_done, underrun and s_ready SHALL all be 0.
REQ-031 rst asserted mid-frame SHALL discard the frame and buffered bytes without an underrun pulse.
REQ-032 On the first cycle after rst deasserts, s_ready SHALL be 1.

Configuration
REQ-033 With LFSR_FEEDER_LSB_FIRST_EN defined, bytes SHALL serialize LSB first (shift right, lfsr_sin = bit 0).
REQ-034 With LFSR_FEEDER_LSB_FIRST_EN undefined, MSB-first order per REQ-020 SHALL apply; all timing SHALL be identical in both builds.

Verification
REQ-035 Reset then single byte 0xA5, last=1 -> lfsr_sin 1,0,1,0,0,1,0,1 with bit_valid; then 4 flush zeros; frame_done on the 4th; lfsr_init back to 1.
REQ-036 3-byte frame 0x01,0x80,0xFF pushed back-to-back -> 24 contiguous bit_valid cycles with no gap; s_ready stays high.
REQ-037 Push 0x12 (not last), wait 20 cycles, push 0x34 last -> underrun pulse after 8 bits; 0x34 dropped; no frame_done; next frame OK.
REQ-038 Fill FIFO with 4 bytes in IDLE -> s_ready=0 while full; s_ready=1 after first pop; no byte lost.
REQ-039 rst asserted at bit 3 of a frame with 2 bytes queued -> next cycle all outputs per REQ-030; FIFO empty; no underrun.
REQ-040 LFSR_FEEDER_LSB_FIRST_EN build, byte 0x01 -> first bit 1, then seven 0 bits.
